// File: rtl/cdb_rr_arbiter_if.sv
// Payload type and port bundle for the CDB round-robin arbiter.
// The bundle carries the writeback request handshake, both CDB slots and the debug taps.
package cdb_rr_arbiter_pkg;
  typedef struct packed {
    logic        r_valid;
    logic [5:0]  rob_id;
    logic [31:0] value;
  } cdb_info_t;
endpackage

interface cdb_rr_arbiter_if #(
  parameter int PORT_COUNT = 4
);
  import cdb_rr_arbiter_pkg::*;

  localparam int PTR_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  // Handshake: a writeback entry moves from FIFO head i when req_valid_i[i] &&
  // req_ready_o[i] in the same cycle; ready is combinational from valid/data/flush and
  // may rise only while valid is high. CDB slots have no ready and are always consumed.
  logic                            flush;
  logic      [PORT_COUNT-1:0]      req_valid_i;
  cdb_info_t [PORT_COUNT-1:0]      req_data_i;
  logic      [PORT_COUNT-1:0]      req_ready_o;
  logic      [1:0]                 cdb_valid_o;
  cdb_info_t [1:0]                 cdb_data_o;
  logic      [PORT_COUNT-1:0]      urgent_o;
  logic      [1:0][PTR_W-1:0]      dbg_rr_ptr_o;
  logic      [PORT_COUNT-1:0][3:0] dbg_wait_cnt_o;

  modport master (
    output flush, req_valid_i, req_data_i,
    input  req_ready_o, cdb_valid_o, cdb_data_o, urgent_o, dbg_rr_ptr_o, dbg_wait_cnt_o
  );

  modport slave (
    input  flush, req_valid_i, req_data_i,
    output req_ready_o, cdb_valid_o, cdb_data_o, urgent_o, dbg_rr_ptr_o, dbg_wait_cnt_o
  );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Two-bank CDB arbiter: per-bank round-robin with a lowest-index starvation override.
// Winners are registered onto the bank's CDB slot one cycle after acceptance.
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int PORT_COUNT   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cdb_rr_arbiter_if.slave  bus
);

  localparam int               PTR_W = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam logic [3:0]       LIMIT = 4'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(PORT_COUNT - 1);
  localparam logic [PTR_W:0]   PC    = (PTR_W + 1)'(PORT_COUNT);

  logic      [1:0][PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic      [PORT_COUNT-1:0][3:0] wait_cnt_q, wait_cnt_d;
  logic      [1:0]                 cdb_valid_q, cdb_valid_d;
  cdb_info_t [1:0]                 cdb_data_q, cdb_data_d;

  logic      [1:0][PORT_COUNT-1:0] elig;
  logic      [1:0][PORT_COUNT-1:0] grant;
  logic      [1:0][PTR_W-1:0]      win;
  logic      [1:0]                 hit;
  logic      [PORT_COUNT-1:0]      urgent;
  logic      [PTR_W:0]             scan;

  always_comb begin
    elig        = '0;
    grant       = '0;
    win         = '0;
    hit         = '0;
    urgent      = '0;
    scan        = '0;
    rr_ptr_d    = rr_ptr_q;
    wait_cnt_d  = wait_cnt_q;
    cdb_valid_d = '0;
    cdb_data_d  = '0;

    for (int i = 0; i < PORT_COUNT; i++) begin
      urgent[i] = (wait_cnt_q[i] == LIMIT);
      if (bus.req_valid_i[i] && !bus.flush) begin
        elig[bus.req_data_i[i].rob_id[0]][i] = 1'b1;
      end
    end

    for (int b = 0; b < 2; b++) begin
      // Scans run downward so the last hit is the lowest index / nearest to the pointer.
      for (int i = PORT_COUNT - 1; i >= 0; i--) begin
        if (elig[b][i] && urgent[i]) begin
          win[b] = PTR_W'(i);
          hit[b] = 1'b1;
        end
      end
      if (!hit[b]) begin
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
          scan = {1'b0, rr_ptr_q[b]} + (PTR_W + 1)'(k);
          if (scan >= PC) begin
            scan = scan - PC;
          end
          if (elig[b][scan[PTR_W-1:0]]) begin
            win[b] = scan[PTR_W-1:0];
            hit[b] = 1'b1;
          end
        end
      end
      if (hit[b]) begin
        grant[b][win[b]] = 1'b1;
        rr_ptr_d[b]      = (win[b] == LAST) ? '0 : win[b] + 1'b1;
        cdb_valid_d[b]   = 1'b1;
        cdb_data_d[b]    = bus.req_data_i[win[b]];
      end
    end

    for (int i = 0; i < PORT_COUNT; i++) begin
      if ((elig[0][i] || elig[1][i]) && !(grant[0][i] || grant[1][i])) begin
        wait_cnt_d[i] = (wait_cnt_q[i] == LIMIT) ? LIMIT : wait_cnt_q[i] + 4'd1;
      end else begin
        wait_cnt_d[i] = '0;
      end
    end

    if (bus.flush) begin
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      cdb_valid_q <= '0;
      cdb_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  // Ready is gated by rst_n so nothing pops while reset is held.
  assign bus.req_ready_o    = (grant[0] | grant[1]) & {PORT_COUNT{rst_n}};
  assign bus.cdb_valid_o    = cdb_valid_q;
  assign bus.cdb_data_o     = cdb_data_q;
  assign bus.urgent_o       = urgent;
  assign bus.dbg_rr_ptr_o   = rr_ptr_q;
  assign bus.dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: one DUT with STARVE_LIMIT=8 for rotation/flush/reset,
// a second with STARVE_LIMIT=2 for the urgent override.
module tb_cdb_rr_arbiter;
  import cdb_rr_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  cdb_rr_arbiter_if #(.PORT_COUNT(4)) bus   ();
  cdb_rr_arbiter_if #(.PORT_COUNT(4)) bus_s ();

  cdb_rr_arbiter #(.PORT_COUNT(4), .STARVE_LIMIT(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  cdb_rr_arbiter #(.PORT_COUNT(4), .STARVE_LIMIT(2)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  function automatic cdb_info_t mk(input logic [5:0] rob);
    cdb_info_t e;
    e.r_valid = 1'b1;
    e.rob_id  = rob;
    e.value   = 32'hA500_0000 | {26'd0, rob};
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [5:0] rob);
    bus.req_valid_i[p] = 1'b1;
    bus.req_data_i[p]  = mk(rob);
  endtask

  task automatic clear_ports();
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_port(0, 6'd2);
    #12;
    n_checks++; if (bus.req_ready_o !== 4'b0000) $display("FAIL reset_ready_held: got %b expected 0000", bus.req_ready_o); else n_pass++;
    n_checks++; if (bus.cdb_valid_o !== 2'b00) $display("FAIL reset_valid_held: got %b expected 00", bus.cdb_valid_o); else n_pass++;
    clear_ports();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (bus.cdb_valid_o !== 2'b00) $display("FAIL reset_valid: got %b expected 00", bus.cdb_valid_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o !== '0) $display("FAIL reset_data: got %h expected 0", bus.cdb_data_o); else n_pass++;
    n_checks++; if (bus.urgent_o !== 4'b0000) $display("FAIL reset_urgent: got %b expected 0000", bus.urgent_o); else n_pass++;
    n_checks++; if (bus.req_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o); else n_pass++;
    n_checks++; if (bus.dbg_rr_ptr_o !== 4'b0000) $display("FAIL reset_rr_ptr: got %b expected 0000", bus.dbg_rr_ptr_o); else n_pass++;
    step();
  endtask

  task automatic test_rr_bank0();
    logic [3:0] exp_rdy [3] = '{4'b0001, 4'b0010, 4'b0001};
    logic [1:0] exp_v   [3] = '{2'b00, 2'b01, 2'b01};
    logic [5:0] exp_rob [3] = '{6'd0, 6'd2, 6'd4};
    set_port(0, 6'd2);
    set_port(1, 6'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (bus.req_ready_o !== exp_rdy[c]) $display("FAIL rr_ready c%0d: got %b expected %b", c, bus.req_ready_o, exp_rdy[c]); else n_pass++;
      n_checks++; if (bus.cdb_valid_o !== exp_v[c]) $display("FAIL rr_valid c%0d: got %b expected %b", c, bus.cdb_valid_o, exp_v[c]); else n_pass++;
      if (exp_v[c][0]) begin
        n_checks++; if (bus.cdb_data_o[0] !== mk(exp_rob[c])) $display("FAIL rr_data c%0d: got %h expected %h", c, bus.cdb_data_o[0], mk(exp_rob[c])); else n_pass++;
      end
      step();
    end
    clear_ports();
    @(negedge clk);
    n_checks++; if (bus.cdb_data_o[0] !== mk(6'd2)) $display("FAIL rr_data_last: got %h expected %h", bus.cdb_data_o[0], mk(6'd2)); else n_pass++;
    n_checks++; if (bus.dbg_rr_ptr_o[0] !== 2'd1) $display("FAIL rr_ptr0: got %0d expected 1", bus.dbg_rr_ptr_o[0]); else n_pass++;
    step();
  endtask

  task automatic test_dual_bank();
    set_port(0, 6'd5);
    set_port(3, 6'd6);
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 4'b1001) $display("FAIL dual_ready: got %b expected 1001", bus.req_ready_o); else n_pass++;
    step();
    clear_ports();
    @(negedge clk);
    n_checks++; if (bus.cdb_valid_o !== 2'b11) $display("FAIL dual_valid: got %b expected 11", bus.cdb_valid_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o[1] !== mk(6'd5)) $display("FAIL dual_data1: got %h expected %h", bus.cdb_data_o[1], mk(6'd5)); else n_pass++;
    n_checks++; if (bus.cdb_data_o[0] !== mk(6'd6)) $display("FAIL dual_data0: got %h expected %h", bus.cdb_data_o[0], mk(6'd6)); else n_pass++;
    n_checks++; if (bus.dbg_rr_ptr_o !== {2'd1, 2'd0}) $display("FAIL dual_rr_ptr: got %b expected 0100", bus.dbg_rr_ptr_o); else n_pass++;
    step();
  endtask

  task automatic test_wrap();
    set_port(2, 6'd7);
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 4'b0100) $display("FAIL wrap_ready_a: got %b expected 0100", bus.req_ready_o); else n_pass++;
    step();
    clear_ports();
    set_port(0, 6'd9);
    set_port(3, 6'd11);
    @(negedge clk);
    n_checks++; if (bus.dbg_rr_ptr_o[1] !== 2'd3) $display("FAIL wrap_ptr_b: got %0d expected 3", bus.dbg_rr_ptr_o[1]); else n_pass++;
    n_checks++; if (bus.req_ready_o !== 4'b1000) $display("FAIL wrap_ready_b: got %b expected 1000", bus.req_ready_o); else n_pass++;
    step();
    @(negedge clk);
    n_checks++; if (bus.dbg_rr_ptr_o[1] !== 2'd0) $display("FAIL wrap_ptr_c: got %0d expected 0", bus.dbg_rr_ptr_o[1]); else n_pass++;
    n_checks++; if (bus.req_ready_o !== 4'b0001) $display("FAIL wrap_ready_c: got %b expected 0001", bus.req_ready_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o[1] !== mk(6'd11)) $display("FAIL wrap_data_c: got %h expected %h", bus.cdb_data_o[1], mk(6'd11)); else n_pass++;
    step();
    clear_ports();
    @(negedge clk);
    n_checks++; if (bus.cdb_data_o[1] !== mk(6'd9)) $display("FAIL wrap_data_d: got %h expected %h", bus.cdb_data_o[1], mk(6'd9)); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ev [3] = '{6'd2, 6'd4, 6'd6};
    logic [5:0] od [3] = '{6'd1, 6'd3, 6'd5};
    for (int c = 0; c < 3; c++) begin
      set_port(1, ev[c]);
      set_port(2, od[c]);
      @(negedge clk);
      n_checks++; if (bus.req_ready_o !== 4'b0110) $display("FAIL b2b_ready c%0d: got %b expected 0110", c, bus.req_ready_o); else n_pass++;
      if (c > 0) begin
        n_checks++; if (bus.cdb_data_o !== {mk(od[c-1]), mk(ev[c-1])}) $display("FAIL b2b_data c%0d: got %h expected %h", c, bus.cdb_data_o, {mk(od[c-1]), mk(ev[c-1])}); else n_pass++;
      end
      step();
    end
    clear_ports();
    @(negedge clk);
    n_checks++; if (bus.cdb_data_o !== {mk(6'd5), mk(6'd6)}) $display("FAIL b2b_data_last: got %h expected %h", bus.cdb_data_o, {mk(6'd5), mk(6'd6)}); else n_pass++;
    step();
  endtask

  task automatic test_flush();
    set_port(0, 6'd2);
    set_port(1, 6'd4);
    set_port(2, 6'd1);
    step();
    bus.flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 4'b0000) $display("FAIL flush_ready: got %b expected 0000", bus.req_ready_o); else n_pass++;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cdb_valid_o !== 2'b00) $display("FAIL flush_valid: got %b expected 00", bus.cdb_valid_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o !== '0) $display("FAIL flush_data: got %h expected 0", bus.cdb_data_o); else n_pass++;
    n_checks++; if (bus.dbg_rr_ptr_o !== 4'b0000) $display("FAIL flush_rr_ptr: got %b expected 0000", bus.dbg_rr_ptr_o); else n_pass++;
    n_checks++; if (bus.dbg_wait_cnt_o !== 16'h0000) $display("FAIL flush_wait: got %h expected 0000", bus.dbg_wait_cnt_o); else n_pass++;
    n_checks++; if (bus.req_ready_o !== 4'b0101) $display("FAIL flush_reready: got %b expected 0101", bus.req_ready_o); else n_pass++;
    step();
    clear_ports();
    @(negedge clk);
    n_checks++; if (bus.cdb_valid_o !== 2'b11) $display("FAIL flush_post_valid: got %b expected 11", bus.cdb_valid_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o !== {mk(6'd1), mk(6'd2)}) $display("FAIL flush_post_data: got %h expected %h", bus.cdb_data_o, {mk(6'd1), mk(6'd2)}); else n_pass++;
    step();
  endtask

  task automatic test_starve();
    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    logic [3:0] exp_urg [5] = '{4'b0000, 4'b0000, 4'b1100, 4'b1001, 4'b1010};
    for (int p = 0; p < 4; p++) begin
      bus_s.req_valid_i[p] = 1'b1;
      bus_s.req_data_i[p]  = mk(6'(2 * p));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus_s.req_ready_o !== exp_rdy[c]) $display("FAIL starve_ready c%0d: got %b expected %b", c, bus_s.req_ready_o, exp_rdy[c]); else n_pass++;
      n_checks++; if (bus_s.urgent_o !== exp_urg[c]) $display("FAIL starve_urgent c%0d: got %b expected %b", c, bus_s.urgent_o, exp_urg[c]); else n_pass++;
      step();
    end
    bus_s.req_valid_i = '0;
    bus_s.req_data_i  = '0;
    step();
  endtask

  task automatic test_reset_mid();
    set_port(0, 6'd8);
    step();
    clear_ports();
    n_checks++; if (bus.cdb_valid_o !== 2'b01) $display("FAIL midrst_inflight: got %b expected 01", bus.cdb_valid_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.cdb_valid_o !== 2'b00) $display("FAIL midrst_valid: got %b expected 00", bus.cdb_valid_o); else n_pass++;
    n_checks++; if (bus.cdb_data_o !== '0) $display("FAIL midrst_data: got %h expected 0", bus.cdb_data_o); else n_pass++;
    n_checks++; if (bus.dbg_rr_ptr_o !== 4'b0000) $display("FAIL midrst_rr_ptr: got %b expected 0000", bus.dbg_rr_ptr_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.flush         = 1'b0;
    bus_s.flush       = 1'b0;
    bus_s.req_valid_i = '0;
    bus_s.req_data_i  = '0;
    clear_ports();
    test_reset();
    test_rr_bank0();
    test_dual_bank();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
